// File: rtl/pc_fetch.sv
// Program-counter fetch unit: issues one instruction-memory request at a time,
// holds the returned word for downstream and handles branch redirects and kills.
module pc_fetch #(
    parameter int unsigned                  DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]        RESET_VECTOR = DATA_WIDTH'(32'h0000_0000)
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  branch_valid_in,
    input  logic [DATA_WIDTH-1:0] branch_target_in,
    output logic                  imem_req_valid_out,
    input  logic                  imem_req_ready_in,
    output logic [DATA_WIDTH-1:0] imem_addr_out,
    input  logic                  imem_rsp_valid_in,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_in,
    output logic                  inst_valid_out,
    input  logic                  inst_ready_in,
    output logic [DATA_WIDTH-1:0] inst_data_out,
    output logic [DATA_WIDTH-1:0] inst_pc_out
);

    localparam int unsigned ALIGN_W = 2;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  kill_q, kill_d;
    logic                  req_valid_q, req_valid_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [DATA_WIDTH-1:0] target_c;
    logic                  tgt_lsb_unused;

    // Branch targets are word aligned; the low bits are dropped.
    assign target_c       = {branch_target_in[DATA_WIDTH-1:ALIGN_W], ALIGN_W'(0)};
    assign tgt_lsb_unused = ^branch_target_in[ALIGN_W-1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        data_d  = data_q;
        kill_d  = kill_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (branch_valid_in) pc_d = target_c;
            end
            ST_REQ: begin
                if (imem_req_ready_in) begin
                    state_d = ST_WAIT;
                    if (branch_valid_in) begin
                        pc_d   = target_c;
                        kill_d = 1'b1;
                    end
                end else if (branch_valid_in) begin
                    pc_d = target_c;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid_in) begin
                    kill_d = 1'b0;
                    if (branch_valid_in || kill_q) begin
                        // Response belongs to a redirected path: drop it and refetch.
                        state_d = ST_REQ;
                        if (branch_valid_in) pc_d = target_c;
                    end else begin
                        data_d  = imem_rsp_data_in;
                        state_d = ST_HOLD;
                    end
                end else if (branch_valid_in) begin
                    pc_d   = target_c;
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (branch_valid_in) begin
                    pc_d    = target_c;
                    state_d = ST_REQ;
                end else if (inst_ready_in) begin
                    pc_d    = pc_q + DATA_WIDTH'(INST_BYTES);
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_valid_d  = (state_d == ST_REQ);
        inst_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            data_q       <= '0;
            kill_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            data_q       <= data_d;
            kill_q       <= kill_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req_valid_out = req_valid_q;
    assign imem_addr_out      = pc_q;
    assign inst_valid_out     = inst_valid_q;
    assign inst_data_out      = data_q;
    assign inst_pc_out        = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: table of fetch transactions checked through a
// scoreboard, plus hand-written redirect, wrap and reset sequences.
module tb_pc_fetch;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        branch_valid_in;
    logic [31:0] branch_target_in;
    logic        imem_req_valid_out;
    logic        imem_req_ready_in;
    logic [31:0] imem_addr_out;
    logic        imem_rsp_valid_in;
    logic [31:0] imem_rsp_data_in;
    logic        inst_valid_out;
    logic        inst_ready_in;
    logic [31:0] inst_data_out;
    logic [31:0] inst_pc_out;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock_in = ~clock_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    pc_fetch #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .branch_valid_in    (branch_valid_in),
        .branch_target_in   (branch_target_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_addr_out      (imem_addr_out),
        .imem_rsp_valid_in  (imem_rsp_valid_in),
        .imem_rsp_data_in   (imem_rsp_data_in),
        .inst_valid_out     (inst_valid_out),
        .inst_ready_in      (inst_ready_in),
        .inst_data_out      (inst_data_out),
        .inst_pc_out        (inst_pc_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic accept();
        imem_req_ready_in = 1'b1;
        step();
        imem_req_ready_in = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid_out) break;
            step();
        end
        chk("req_wait", 32'(imem_req_valid_out), 32'd1);
    endtask

    // One complete fetch: request, 1-cycle response, hold, optional consume.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int stall, input int hold, input bit consume);
        exp_t e;
        wait_req();
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_req_valid", 32'(imem_req_valid_out), 32'd1);
        end
        chk("req_addr", imem_addr_out, addr);
        accept();
        sb.push_back('{pc: addr, data: data});
        chk("one_outstanding", 32'(imem_req_valid_out), 32'd0);
        chk("wait_no_inst", 32'(inst_valid_out), 32'd0);
        imem_rsp_valid_in = 1'b1;
        imem_rsp_data_in  = data;
        step();
        imem_rsp_valid_in = 1'b0;
        imem_rsp_data_in  = $urandom;
        chk("rsp_inst_latency", 32'(inst_valid_out), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got empty scoreboard required one entry");
        end else begin
            e = sb.pop_front();
            chk("inst_data", inst_data_out, e.data);
            chk("inst_pc", inst_pc_out, e.pc);
            for (int i = 0; i < hold; i++) begin
                step();
                chk("hold_valid", 32'(inst_valid_out), 32'd1);
                chk("hold_data", inst_data_out, e.data);
                chk("hold_pc", inst_pc_out, e.pc);
                chk("hold_no_req", 32'(imem_req_valid_out), 32'd0);
            end
        end
        if (consume) begin
            inst_ready_in = 1'b1;
            step();
            inst_ready_in = 1'b0;
            chk("consume_drop_valid", 32'(inst_valid_out), 32'd0);
            chk("consume_req", 32'(imem_req_valid_out), 32'd1);
            chk("next_addr", imem_addr_out, addr + 32'd4);
        end
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, data: 32'h1111_0000, stall: 0, hold: 0};
        vecs[1] = '{addr: 32'h0000_0004, data: 32'h2222_0004, stall: 2, hold: 0};
        vecs[2] = '{addr: 32'h0000_0008, data: 32'h3333_0008, stall: 0, hold: 5};
        vecs[3] = '{addr: 32'h0000_000C, data: 32'h4444_000C, stall: 1, hold: 1};

        reset_in          = 1'b0;
        branch_valid_in   = 1'b0;
        branch_target_in  = '0;
        imem_req_ready_in = 1'b0;
        imem_rsp_valid_in = 1'b0;
        imem_rsp_data_in  = '0;
        inst_ready_in     = 1'b0;
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid_out), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_out), 32'd0);
        chk("rst_inst_data", inst_data_out, 32'd0);
        chk("rst_inst_pc", inst_pc_out, 32'd0);
        chk("rst_addr", imem_addr_out, 32'd0);

        reset_in = 1'b1;
        step();
        chk("first_req_latency", 32'(imem_req_valid_out), 32'd1);

        for (int i = 0; i < 4; i++)
            fetch(vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].hold, 1'b1);

        // Branch while waiting: late response is killed, refetch aligned target.
        wait_req();
        chk("kill_pre_addr", imem_addr_out, 32'h0000_0010);
        accept();
        branch_valid_in  = 1'b1;
        branch_target_in = 32'h0000_1003;
        step();
        branch_valid_in = 1'b0;
        chk("kill_wait_no_req", 32'(imem_req_valid_out), 32'd0);
        imem_rsp_valid_in = 1'b1;
        imem_rsp_data_in  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid_in = 1'b0;
        chk("kill_no_inst", 32'(inst_valid_out), 32'd0);
        chk("kill_req", 32'(imem_req_valid_out), 32'd1);
        chk("kill_addr", imem_addr_out, 32'h0000_1000);
        step();
        chk("kill_no_inst_later", 32'(inst_valid_out), 32'd0);
        fetch(32'h0000_1000, 32'h5555_1000, 0, 0, 1'b1);

        // Branch in HOLD overrides a same-cycle consume.
        fetch(32'h0000_1004, 32'h6666_1004, 0, 0, 1'b0);
        branch_valid_in  = 1'b1;
        branch_target_in = 32'h0000_2000;
        inst_ready_in    = 1'b1;
        step();
        branch_valid_in = 1'b0;
        inst_ready_in   = 1'b0;
        chk("hold_br_valid", 32'(inst_valid_out), 32'd0);
        chk("hold_br_req", 32'(imem_req_valid_out), 32'd1);
        chk("hold_br_addr", imem_addr_out, 32'h0000_2000);

        // Branch with same-cycle handshake: the issued request is killed.
        imem_req_ready_in = 1'b1;
        branch_valid_in   = 1'b1;
        branch_target_in  = 32'h0000_3000;
        step();
        imem_req_ready_in = 1'b0;
        branch_valid_in   = 1'b0;
        chk("req_br_wait", 32'(imem_req_valid_out), 32'd0);
        imem_rsp_valid_in = 1'b1;
        imem_rsp_data_in  = 32'h7777_7777;
        step();
        imem_rsp_valid_in = 1'b0;
        chk("req_br_no_inst", 32'(inst_valid_out), 32'd0);
        chk("req_br_addr", imem_addr_out, 32'h0000_3000);

        // Branch and response in the same WAIT cycle: response dropped.
        accept();
        branch_valid_in   = 1'b1;
        branch_target_in  = 32'h0000_4000;
        imem_rsp_valid_in = 1'b1;
        imem_rsp_data_in  = 32'h1234_5678;
        step();
        branch_valid_in   = 1'b0;
        imem_rsp_valid_in = 1'b0;
        chk("wait_br_rsp_no_inst", 32'(inst_valid_out), 32'd0);
        chk("wait_br_rsp_req", 32'(imem_req_valid_out), 32'd1);
        chk("wait_br_rsp_addr", imem_addr_out, 32'h0000_4000);

        // Unaccepted branch in REQ, then PC wrap at the top of memory.
        branch_valid_in  = 1'b1;
        branch_target_in = 32'hFFFF_FFFF;
        step();
        branch_valid_in = 1'b0;
        chk("req_redirect_addr", imem_addr_out, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h8888_8888, 0, 0, 1'b1);

        // Asynchronous reset while a request is outstanding.
        accept();
        #3;
        reset_in          = 1'b0;
        imem_rsp_valid_in = 1'b1;
        imem_rsp_data_in  = 32'hBAD0_BAD0;
        #1;
        chk("async_rst_req", 32'(imem_req_valid_out), 32'd0);
        chk("async_rst_inst", 32'(inst_valid_out), 32'd0);
        chk("async_rst_data", inst_data_out, 32'd0);
        chk("async_rst_pc", inst_pc_out, 32'd0);
        step();
        step();
        chk("rst_rsp_ignored", 32'(inst_valid_out), 32'd0);
        imem_rsp_valid_in = 1'b0;
        reset_in          = 1'b1;
        step();
        chk("restart_req", 32'(imem_req_valid_out), 32'd1);
        chk("restart_addr", imem_addr_out, 32'd0);
        chk("restart_no_inst", 32'(inst_valid_out), 32'd0);
        fetch(32'h0000_0000, 32'hAAAA_0000, 0, 0, 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
